// File: rtl/io_slave_regbank.sv
// Register bank slave: ID, free-running cycle counter and R/W storage behind a
// single-outstanding-read IO request interface with fixed read latency.
package io_slave_regbank_pkg;
  typedef logic [3:0]  thread_id_t;
  typedef logic [31:0] address_t;
  typedef logic [31:0] register_t;
  typedef enum logic {IO_READ = 1'b0, IO_WRITE = 1'b1} io_operation_t;
endpackage

module io_slave_regbank
  import io_slave_regbank_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hFF00_0000,
  parameter int          NUM_REGS     = 16,
  parameter int          READ_LATENCY = 2,
  parameter logic [31:0] ID_VALUE     = 32'h4E50_5530
) (
  input  logic                               clk,
  input  logic                               reset,
  output logic                               slave_available_to_io_intf,
  input  logic                               io_intf_valid,
  input  thread_id_t                         io_intf_thread,
  input  logic [$bits(io_operation_t)-1:0]   io_intf_operation,
  input  address_t                           io_intf_address,
  input  register_t                          io_intf_data,
  output logic                               slave_resp_valid,
  output thread_id_t                         slave_wakeup_thread,
  output register_t                          slave_resp_data,
  input  logic                               io_intf_resp_consumed
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W = $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  register_t        cycle_count;
  register_t        regs [2:NUM_REGS-1];

  address_t         offset;
  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             accept;
  logic             is_write;
  register_t        rd_data;

  // Subtraction wraps modulo 2^32, so addresses below BASE_ADDR land far out of range.
  assign offset   = io_intf_address - BASE_ADDR;
  assign in_range = (offset[1:0] == 2'b00) && (offset < 32'(4 * NUM_REGS));
  assign idx      = offset[IDX_W+1:2];
  assign accept   = io_intf_valid & slave_available_to_io_intf;
  assign is_write = (io_intf_operation == IO_WRITE);

  always_comb begin
    rd_data = '0;
    if (in_range) begin
      if (idx == IDX_W'(0))      rd_data = ID_VALUE;
      else if (idx == IDX_W'(1)) rd_data = cycle_count;
      else                       rd_data = regs[idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cycle_count <= '0;
    else        cycle_count <= cycle_count + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 2; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (accept && is_write && in_range && (idx >= IDX_W'(2))) begin
      regs[idx] <= io_intf_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                      <= IDLE;
      wait_cnt                   <= '0;
      slave_available_to_io_intf <= 1'b1;
      slave_resp_valid           <= 1'b0;
      slave_wakeup_thread        <= '0;
      slave_resp_data            <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && !is_write) begin
            state                      <= WAIT;
            wait_cnt                   <= CNT_W'(READ_LATENCY);
            slave_available_to_io_intf <= 1'b0;
            slave_wakeup_thread        <= io_intf_thread;
            slave_resp_data            <= rd_data;
          end
        end
        WAIT: begin
          if (wait_cnt == CNT_W'(1)) begin
            state            <= RESP;
            wait_cnt         <= '0;
            slave_resp_valid <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (io_intf_resp_consumed) begin
            state                      <= IDLE;
            slave_resp_valid           <= 1'b0;
            slave_available_to_io_intf <= 1'b1;
          end
        end
        default: begin
          state                      <= IDLE;
          slave_resp_valid           <= 1'b0;
          slave_available_to_io_intf <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_slave_regbank.sv
// Bench for io_slave_regbank: transaction-level model plus per-cycle compare and
// directed scenarios with literal expectations.
module tb_io_slave_regbank;
  import io_slave_regbank_pkg::*;

  localparam logic [31:0] BASE = 32'hFF00_0000;
  localparam int          NREG = 16;
  localparam int          LAT  = 2;
  localparam logic [31:0] IDV  = 32'h4E50_5530;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          avail;
  logic          io_intf_valid = 1'b0;
  thread_id_t    io_intf_thread = '0;
  io_operation_t io_intf_operation = IO_READ;
  address_t      io_intf_address = '0;
  register_t     io_intf_data = '0;
  logic          resp_valid;
  thread_id_t    resp_thread;
  register_t     resp_data;
  logic          io_intf_resp_consumed = 1'b0;

  int checks = 0;
  int errors = 0;

  io_slave_regbank #(
    .BASE_ADDR(BASE), .NUM_REGS(NREG), .READ_LATENCY(LAT), .ID_VALUE(IDV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .slave_available_to_io_intf(avail),
    .io_intf_valid(io_intf_valid),
    .io_intf_thread(io_intf_thread),
    .io_intf_operation(io_intf_operation),
    .io_intf_address(io_intf_address),
    .io_intf_data(io_intf_data),
    .slave_resp_valid(resp_valid),
    .slave_wakeup_thread(resp_thread),
    .slave_resp_data(resp_data),
    .io_intf_resp_consumed(io_intf_resp_consumed)
  );

  always #5 clk = ~clk;

  // Model: counter value = edges since reset + offset; a read answers from edge accept+LAT.
  logic [31:0] m_reg [NREG];
  logic [31:0] m_edge = '0;
  logic [31:0] m_resp_edge = '0;
  logic [31:0] m_data = '0;
  logic [3:0]  m_thr = '0;
  bit          m_pend = 1'b0;
  logic [31:0] cnt_offset = '0;

  function automatic bit m_in_range(logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off % 4 == 0) && (off < 4 * NREG);
  endfunction

  function automatic logic [31:0] m_read(logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (!m_in_range(a)) return 32'h0;
    if (off / 4 == 0)   return IDV;
    if (off / 4 == 1)   return m_edge + cnt_offset;
    return m_reg[off / 4];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_edge = '0; m_pend = 1'b0; m_resp_edge = '0; m_data = '0; m_thr = '0;
      foreach (m_reg[i]) m_reg[i] = '0;
    end else begin
      if (m_pend && m_edge >= m_resp_edge) begin
        if (io_intf_resp_consumed) m_pend = 1'b0;
      end else if (!m_pend && io_intf_valid) begin
        if (io_intf_operation == IO_WRITE) begin
          if (m_in_range(io_intf_address) && (io_intf_address - BASE) / 4 >= 2)
            m_reg[(io_intf_address - BASE) / 4] = io_intf_data;
        end else begin
          m_pend      = 1'b1;
          m_data      = m_read(io_intf_address);
          m_thr       = io_intf_thread;
          m_resp_edge = m_edge + 1 + LAT;
        end
      end
      m_edge = m_edge + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    io_intf_valid = 1'b1; io_intf_operation = IO_WRITE; io_intf_address = a; io_intf_data = d;
    @(posedge clk); #1;
    io_intf_valid = 1'b0;
  endtask

  // hold: cycles to keep consumed low in RESP; poke: stray consumed in WAIT and writes in RESP.
  task automatic do_read(input logic [31:0] a, input logic [3:0] thr, input int hold, input bit poke,
                         output logic [31:0] d, output logic [3:0] t, output int lat,
                         output logic [31:0] acc);
    io_intf_valid = 1'b1; io_intf_operation = IO_READ; io_intf_address = a; io_intf_thread = thr;
    @(posedge clk); #1;
    io_intf_valid = 1'b0;
    acc = m_edge;
    lat = 1;
    chk("avail_low_after_accept", {31'b0, avail}, 32'd0);
    while (!resp_valid && lat < 40) begin
      io_intf_resp_consumed = poke && (lat == 1);
      @(posedge clk); #1;
      lat++;
    end
    io_intf_resp_consumed = 1'b0;
    d = resp_data;
    t = resp_thread;
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        io_intf_valid = 1'b1; io_intf_operation = IO_WRITE;
        io_intf_address = BASE + 32'd12; io_intf_data = 32'hFACE_0000 + i;
      end
      @(posedge clk); #1;
      io_intf_valid = 1'b0;
    end
    io_intf_resp_consumed = 1'b1;
    @(posedge clk); #1;
    io_intf_resp_consumed = 1'b0;
    chk("avail_after_consume", {31'b0, avail}, 32'd1);
  endtask

  logic [31:0] d, v1, v2, a1, a2, acc;
  logic [3:0]  t;
  int          lat;

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!reset) begin
          chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
          chk("rst_resp_data", resp_data, 32'd0);
          chk("rst_resp_thread", {28'b0, resp_thread}, 32'd0);
        end else begin
          chk("avail", {31'b0, avail}, {31'b0, !m_pend});
          chk("resp_valid", {31'b0, resp_valid}, {31'b0, m_pend && m_edge >= m_resp_edge});
          if (m_pend && m_edge >= m_resp_edge) begin
            chk("resp_thread", {28'b0, resp_thread}, {28'b0, m_thr});
            chk("resp_data", resp_data, m_data);
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    chk("reset_avail", {31'b0, avail}, 32'd1);
    chk("reset_valid", {31'b0, resp_valid}, 32'd0);

    // Basic write then read with latency.
    do_write(BASE + 32'd8, 32'hA5A5_0001);
    do_read(BASE + 32'd8, 4'd3, 0, 1'b0, d, t, lat, acc);
    chk("rd8_data", d, 32'hA5A5_0001);
    chk("rd8_thread", {28'b0, t}, 32'd3);
    chk("rd8_latency", lat, 32'd3);

    // ID register is read-only.
    do_read(BASE, 4'd1, 0, 1'b0, d, t, lat, acc);
    chk("id_read", d, 32'h4E50_5530);
    do_write(BASE, 32'h0);
    do_write(BASE + 32'd4, 32'h0);
    do_read(BASE, 4'd1, 0, 1'b0, d, t, lat, acc);
    chk("id_after_write", d, 32'h4E50_5530);

    // Counter delta.
    do_read(BASE + 32'd4, 4'd2, 0, 1'b0, v1, t, lat, a1);
    repeat (5) @(posedge clk);
    #1;
    do_read(BASE + 32'd4, 4'd2, 0, 1'b0, v2, t, lat, a2);
    chk("cnt_delta_edges", v2 - v1, a2 - a1);
    chk("cnt_delta_literal", v2 - v1, 32'd9);

    // Counter wrap.
    force dut.cycle_count = 32'hFFFF_FFFE;
    cnt_offset = 32'hFFFF_FFFE - m_edge;
    #1 release dut.cycle_count;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    do_read(BASE + 32'd4, 4'd9, 0, 1'b0, d, t, lat, acc);
    chk("cnt_wrap", d, 32'd1);

    // Fill storage, back-to-back, then hit illegal addresses.
    for (int i = 3; i < NREG; i++) do_write(BASE + 4 * i, 32'h1000_0000 + i);
    do_write(BASE + 32'd64, 32'hDEAD_0001);
    do_write(BASE + 32'd2,  32'hDEAD_0002);
    do_write(BASE + 32'h48, 32'hDEAD_0003);
    do_write(BASE - 32'd4,  32'hDEAD_0004);
    do_read(BASE + 32'd64, 4'd4, 0, 1'b0, d, t, lat, acc);
    chk("oor_read", d, 32'h0);
    do_read(BASE + 32'd2, 4'd4, 0, 1'b0, d, t, lat, acc);
    chk("misaligned_read", d, 32'h0);
    do_read(BASE - 32'd4, 4'd4, 0, 1'b0, d, t, lat, acc);
    chk("below_base_read", d, 32'h0);
    for (int i = 2; i < NREG; i++) begin
      do_read(BASE + 4 * i, 4'(i), 0, 1'b0, d, t, lat, acc);
      chk("storage_read", d, (i == 2) ? 32'hA5A5_0001 : 32'h1000_0000 + i);
    end

    // Long RESP hold with stray traffic.
    do_read(BASE + 32'd8, 4'd7, 10, 1'b1, d, t, lat, acc);
    chk("hold_data", d, 32'hA5A5_0001);
    chk("hold_thread", {28'b0, t}, 32'd7);
    do_read(BASE + 32'd12, 4'd7, 0, 1'b0, d, t, lat, acc);
    chk("resp_write_ignored", d, 32'h1000_0003);

    // Reset mid-WAIT.
    io_intf_valid = 1'b1; io_intf_operation = IO_READ;
    io_intf_address = BASE + 32'd8; io_intf_thread = 4'd5;
    @(posedge clk); #1;
    io_intf_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    cnt_offset = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    chk("post_reset_avail", {31'b0, avail}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("post_reset_no_resp", {31'b0, resp_valid}, 32'd0);
    end
    for (int i = 2; i < NREG; i++) begin
      do_read(BASE + 4 * i, 4'd1, 0, 1'b0, d, t, lat, acc);
      chk("post_reset_storage", d, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_slave_regbank.md
IO_SLAVE_REGBANK -- requirements
Module: io_slave_regbank

Interface
REQ-001 The block SHALL provide these parameters (name, default, meaning):
- BASE_ADDR, 32'hFF00_0000, first byte address decoded by the bank.
- NUM_REGS, 16, number of 32-bit registers; power of two, at least 4.
- READ_LATENCY, 2, cycles spent in WAIT before a read response; at least 1.
- ID_VALUE, 32'h4E50_5530, constant returned by register 0.

REQ-002 The block SHALL provide these ports (name, direction, width, meaning):
- clk, in, 1, single clock; every flop is rising-edge.
- reset, in, 1, asynchronous, active-low reset.
- slave_available_to_io_intf, out, 1, bank can accept a request this cycle.
- io_intf_valid, in, 1, request strobe.
- io_intf_thread, in, thread_id_t, requesting thread.
- io_intf_operation, in, $bits(io_operation_t), IO_READ or IO_WRITE.
- io_intf_address, in, address_t, byte address.
- io_intf_data, in, register_t, write data.
- slave_resp_valid, out, 1, read response valid.
- slave_wakeup_thread, out, thread_id_t, thread being answered.
- slave_resp_data, out, register_t, read data.
- io_intf_resp_consumed, in, 1, requester has taken the response.

Function
REQ-003 The controller SHALL be a three-state machine with states IDLE, WAIT and RESP.
REQ-004 slave_available_to_io_intf SHALL be 1 only in IDLE.
REQ-005 A request SHALL be accepted in a cycle where io_intf_valid & slave_available_to_io_intf; in any other cycle io_intf_valid SHALL be ignored.
REQ-006 Address decode:
- offset = io_intf_address - BASE_ADDR, computed modulo 2^32.
- The access is in range when offset[1:0]==0 and offset < 4*NUM_REGS.
- index = offset[$clog2(NUM_REGS)+1:2].
REQ-007 Register map:
- reg 0 is read-only and returns ID_VALUE.
- reg 1 is read-only and returns a free-running 32-bit cycle counter that increments every cycle and wraps from 32'hFFFF_FFFF to 0.
- regs 2..NUM_REGS-1 are read/write storage.
REQ-008 An accepted IO_WRITE to an in-range read/write register SHALL update it on the accepting edge. An accepted IO_WRITE to reg 0, reg 1 or an out-of-range address SHALL be dropped with no side effect. Writes SHALL produce no response, and the FSM SHALL stay in IDLE.
REQ-009 An accepted IO_READ SHALL capture the thread and the read data on the accepting edge and move the FSM to WAIT. In-range reads return the register value at that edge; out-of-range reads return 32'h0.
REQ-010 WAIT SHALL last exactly READ_LATENCY cycles, counted by a down-counter, then move to RESP. slave_resp_valid therefore rises READ_LATENCY+1 cycles after the acceptance edge.
REQ-011 In RESP:
- slave_resp_valid SHALL be 1.
- slave_wakeup_thread and slave_resp_data SHALL hold the captured values, stable until consumed.
- The FSM SHALL return to IDLE on the edge where io_intf_resp_consumed is 1.
REQ-012 io_intf_resp_consumed SHALL be ignored outside RESP.
REQ-013 slave_resp_valid SHALL be 0 in IDLE and WAIT.
REQ-014 At most one read SHALL be outstanding; back-to-back writes SHALL be accepted one per cycle.
REQ-015 The cycle counter SHALL keep running in every FSM state.
REQ-016 An acceptance in the same cycle as an IDLE return is impossible by construction, because available is low in RESP.

Reset
REQ-017 While reset is 0, the block SHALL force:
- FSM to IDLE and the WAIT counter to 0.
- Storage registers and the cycle counter to 0.
- slave_resp_valid to 0.
- slave_wakeup_thread and slave_resp_data to 0.
- slave_available_to_io_intf to 1 from the first cycle after reset deasserts.
REQ-018 A reset asserted mid-WAIT or mid-RESP SHALL abandon the outstanding read; no response SHALL appear after reset deasserts.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Write 32'hA5A5_0001 to BASE_ADDR+8, then read BASE_ADDR+8 from thread 3 -> available drops; slave_resp_valid rises 3 cycles after acceptance with data 32'hA5A5_0001 and thread 3.
- Read BASE_ADDR+0 -> data 32'h4E50_5530. Write 32'h0 to BASE_ADDR+0, then read again -> still 32'h4E50_5530.
- Read BASE_ADDR+4 twice, N cycles apart -> the difference equals N. Preload the counter near 32'hFFFF_FFFF via a long run or force, then read -> wrap to 0 observed.
- Read BASE_ADDR+64 (out of range) and BASE_ADDR+2 (misaligned) -> data 32'h0; writes to these addresses leave every register unchanged.
- Hold io_intf_resp_consumed low for 10 cycles in RESP -> valid, thread and data stay stable; io_intf_valid pulses during RESP are ignored; consumed=1 -> IDLE next cycle.
- Assert reset during WAIT -> after release, no slave_resp_valid appears, all storage reads 0, and available is 1.
